// File: rtl/ibex_rvfi_trace_buffer.sv
// ibex_rvfi_trace_buffer
//
// Capture buffer for RVFI retirement records. It taps the rvfi_* signals
// beside ibex_top, keeps the selected fields in a flip-flop ring and lets a
// consumer drain them over a valid/ready stream.
//
// Capture modes (latched on arm_i):
//   STREAM : FIFO. Readable while capturing. When full, a retirement is
//            dropped unless a read happens in the same cycle.
//   RING   : free-running. The oldest entry is overwritten when full.
//            Readable only once capture is stopped (DONE).
//   TRIG   : RING behaviour, but capture ends PostTrig writes after the
//            first retirement whose PC matches the latched trigger PC.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   arm_i                 pulse: clear buffer, latch mode/trigger PC, start
//   stop_i                pulse: end capture (CAPT/POST -> DONE)
//   mode_i                0=STREAM, 1=RING, 2=TRIG, 3 acts as STREAM
//   trig_pc_i             trigger PC for TRIG mode
//   rvfi_*                retirement record tap
//   rd_valid_o/rd_ready_i head-of-buffer stream handshake
//   rd_*_o                head entry fields, 0 while rd_valid_o is low
//   level_o               number of entries held
//   drop_cnt_o            retirements dropped or overwritten, saturating
//   state_o               0=IDLE, 1=CAPT, 2=POST, 3=DONE
//   triggered_o           trigger seen since the last arm
//
// Read handshake: an entry is transferred on every rising clk_i edge where
// rd_valid_o and rd_ready_i are both high. rd_valid_o never depends on
// rd_ready_i, and the rd_*_o fields are stable while rd_valid_o is high and
// rd_ready_i is low.

module ibex_rvfi_trace_buffer #(
  parameter int unsigned Depth    = 16,
  parameter int unsigned PostTrig = 4,
  parameter int unsigned DropCntW = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     arm_i,
  input  logic                     stop_i,
  input  logic [1:0]               mode_i,
  input  logic [31:0]              trig_pc_i,
  input  logic                     rvfi_valid,
  input  logic [31:0]              rvfi_pc_rdata,
  input  logic [31:0]              rvfi_insn,
  input  logic [4:0]               rvfi_rd_addr,
  input  logic [31:0]              rvfi_rd_wdata,
  input  logic                     rvfi_trap,
  input  logic                     rvfi_intr,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic [31:0]              rd_pc_o,
  output logic [31:0]              rd_insn_o,
  output logic [4:0]               rd_rd_addr_o,
  output logic [31:0]              rd_rd_wdata_o,
  output logic                     rd_trap_o,
  output logic                     rd_intr_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic [DropCntW-1:0]      drop_cnt_o,
  output logic [1:0]               state_o,
  output logic                     triggered_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = 103;
  // PostTrig is at most Depth-1, so it always fits in a pointer-wide counter.
  localparam int unsigned CW = AW;

  localparam logic [1:0] MODE_STREAM = 2'd0;
  localparam logic [1:0] MODE_RING   = 2'd1;
  localparam logic [1:0] MODE_TRIG   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAPT = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [31:0]           trig_pc_q, trig_pc_d;
  logic                  triggered_q, triggered_d;
  logic [CW-1:0]         post_cnt_q, post_cnt_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DropCntW-1:0]   drop_q, drop_d;
  logic [EW-1:0]         mem_q [Depth];

  logic          capturing;
  logic          full;
  logic          rd_valid;
  logic          rd_fire;
  logic          wr_req;
  logic          wr_en;
  logic          drop_evt;
  logic          overwrite;
  logic          trig_hit;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head;

  assign capturing = (state_q == ST_CAPT) || (state_q == ST_POST);
  assign full      = (level_q == LW'(Depth));

  // STREAM may be drained while capturing; RING/TRIG only after capture ends.
  assign rd_valid = (level_q != '0) &&
                    ((mode_q == MODE_STREAM) ? ((state_q == ST_CAPT) || (state_q == ST_DONE))
                                             : (state_q == ST_DONE));
  assign rd_fire  = rd_valid && rd_ready_i;

  assign wr_req = rvfi_valid && capturing;
  // STREAM refuses a write into a full buffer unless the head leaves this cycle.
  assign wr_en  = wr_req && ((mode_q != MODE_STREAM) || !full || rd_fire);
  // Covers both a STREAM drop and a RING/TRIG overwrite of the oldest entry.
  assign drop_evt  = wr_req && full && !rd_fire;
  assign overwrite = wr_en && full && !rd_fire;

  assign trig_hit = wr_en && (mode_q == MODE_TRIG) && (state_q == ST_CAPT) &&
                    !triggered_q && (rvfi_pc_rdata == trig_pc_q);

  assign wr_entry = {rvfi_pc_rdata, rvfi_insn, rvfi_rd_addr, rvfi_rd_wdata,
                     rvfi_trap, rvfi_intr};

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    trig_pc_d   = trig_pc_q;
    triggered_d = triggered_q;
    post_cnt_d  = post_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    drop_d      = drop_q;

    if (arm_i) begin
      // arm_i wins over every other event, including a same-cycle retirement.
      state_d     = ST_CAPT;
      mode_d      = ((mode_i == MODE_RING) || (mode_i == MODE_TRIG)) ? mode_i : MODE_STREAM;
      trig_pc_d   = trig_pc_i;
      triggered_d = 1'b0;
      post_cnt_d  = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      drop_d      = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_fire || overwrite) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end

      if (wr_en && !rd_fire && !overwrite) begin
        level_d = level_q + LW'(1);
      end else if (rd_fire && !wr_en) begin
        level_d = level_q - LW'(1);
      end

      if (drop_evt && (drop_q != '1)) begin
        drop_d = drop_q + DropCntW'(1);
      end

      if (trig_hit) begin
        triggered_d = 1'b1;
        post_cnt_d  = CW'(PostTrig);
        state_d     = (PostTrig == 0) ? ST_DONE : ST_POST;
      end else if ((state_q == ST_POST) && wr_en) begin
        post_cnt_d = post_cnt_q - CW'(1);
        if (post_cnt_q == CW'(1)) begin
          state_d = ST_DONE;
        end
      end

      // The same-cycle retirement above is still written.
      if (stop_i && capturing) begin
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_STREAM;
      trig_pc_q   <= '0;
      triggered_q <= 1'b0;
      post_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      trig_pc_q   <= trig_pc_d;
      triggered_q <= triggered_d;
      post_cnt_q  <= post_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      drop_q      <= drop_d;
    end
  end

  // Storage carries no reset: stale contents are unreachable once the
  // pointers and level are cleared, and the read fields are gated below.
  always_ff @(posedge clk_i) begin
    if (wr_en && !arm_i && !rst_i) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign head = rd_valid ? mem_q[rd_ptr_q] : '0;

  assign rd_valid_o    = rd_valid;
  assign rd_pc_o       = head[102:71];
  assign rd_insn_o     = head[70:39];
  assign rd_rd_addr_o  = head[38:34];
  assign rd_rd_wdata_o = head[33:2];
  assign rd_trap_o     = head[1];
  assign rd_intr_o     = head[0];
  assign level_o       = level_q;
  assign drop_cnt_o    = drop_q;
  assign state_o       = state_q;
  assign triggered_o   = triggered_q;

endmodule

// File: doc/ibex_rvfi_trace_buffer.md
Name: ibex_rvfi_trace_buffer

Overview:
- Parametrised capture buffer for RVFI retirement records.
- Sits beside ibex_top in tracing builds and taps the same rvfi_* signals the text tracer consumes.
- Stores selected fields in an on-chip ring so that software, a debug bridge or a testbench can drain them over a valid/ready stream.
- Adds three modes: stream/FIFO, free-running ring, and PC-triggered capture with a post-trigger window.

Parameters:
- Depth, 16: number of entries; power of two, minimum 2.
- PostTrig, 4: entries captured after the trigger entry in triggered mode; range 0..Depth-1.
- DropCntW, 16: width of the saturating drop counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active high
- arm_i  in  1  single-cycle pulse; clears buffer, samples mode_i and trig_pc_i, starts capture
- stop_i  in  1  single-cycle pulse; forces DONE
- mode_i  in  2  0=STREAM, 1=RING, 2=TRIG; 3 reserved, treated as STREAM
- trig_pc_i  in  32  trigger PC for TRIG mode
- rvfi_valid  in  1  retirement strobe
- rvfi_pc_rdata  in  32  retired PC
- rvfi_insn  in  32  retired instruction
- rvfi_rd_addr  in  5  destination register
- rvfi_rd_wdata  in  32  destination write data
- rvfi_trap  in  1  trap flag
- rvfi_intr  in  1  interrupt-entry flag
- rd_valid_o  out  1  head entry available
- rd_ready_i  in  1  consumer accepts head entry
- rd_pc_o  out  32  head PC
- rd_insn_o  out  32  head instruction
- rd_rd_addr_o  out  5  head destination register
- rd_rd_wdata_o  out  32  head destination write data
- rd_trap_o  out  1  head trap flag
- rd_intr_o  out  1  head interrupt flag
- level_o  out  $clog2(Depth)+1  entries held
- drop_cnt_o  out  DropCntW  dropped retirements, saturating
- state_o  out  2  0=IDLE, 1=CAPT, 2=POST, 3=DONE
- triggered_o  out  1  trigger seen since last arm

Behaviour:
- Reset: state IDLE; pointers, level_o, drop_cnt_o and triggered_o are 0; rd_valid_o is 0; rd_* data outputs are 0.
- Storage is a flip-flop array of 103-bit entries, with a write pointer, a read pointer and a level counter.
- A write in cycle N is visible to rd_valid_o and level_o in cycle N+1.
- rd_* data outputs are driven combinationally from the entry at the read pointer, gated to 0 when rd_valid_o=0.
- A write occurs only when rvfi_valid=1 and the state is CAPT or POST. In IDLE and DONE retirements are ignored and not counted as drops.
- arm_i, in any state:
  - next cycle: pointers, level, drop_cnt and triggered are cleared; state is CAPT; mode and trigger PC are latched.
  - A same-cycle rvfi_valid is discarded.
  - arm_i has priority over stop_i and over every other event.
- stop_i in CAPT or POST moves the state to DONE; a same-cycle retirement is still written.
- STREAM mode:
  - A read handshake (rd_valid_o & rd_ready_i) is legal in CAPT and DONE.
  - Full and no read in the same cycle: the incoming entry is dropped and drop_cnt increments, saturating at all-ones.
  - Full with a read in the same cycle: the write is accepted and level stays at Depth.
- RING and TRIG modes:
  - rd_valid_o is held 0 until the state is DONE; reads occur only in DONE.
  - Write when full: the oldest entry is overwritten, the read pointer advances and level stays at Depth. drop_cnt increments on each overwrite.
- TRIG mode:
  - In CAPT, the first retirement with rvfi_pc_rdata == latched trigger PC is written and sets triggered_o.
  - If PostTrig=0 the state goes to DONE; otherwise it goes to POST with a counter loaded to PostTrig.
  - Each write in POST decrements the counter. The write that brings it to 0 moves the state to DONE.
  - Later trigger matches are ignored.
- DONE holds its contents until drained or until the next arm_i. Draining to empty leaves the state in DONE.
- rst_i asserted mid-capture or mid-drain returns every output to its reset value on the next edge; no partial entry survives.
- Pointers wrap modulo Depth.

Test Plan:
- Reset with Depth=8: `rst_i` for 2 cycles -> `state_o`=0, `level_o`=0, `rd_valid_o`=0, `drop_cnt_o`=0.
- STREAM, full: 10 retirements with `pc`=0x100..0x124, `rd_ready_i`=0 -> `level_o`=8 and `drop_cnt_o`=2. Then drain -> PCs 0x100..0x11C in order.
- STREAM, simultaneous read/write: full buffer, `rd_ready_i`=1 plus `rvfi_valid`=1 for 4 cycles -> `level_o` stays 8, `drop_cnt_o` unchanged.
- RING, wrap: 12 retirements with `pc`=0x0..0x2C, then `stop_i` -> DONE, `drop_cnt_o`=4, drain yields 0x10..0x2C.
- TRIG with PostTrig=2: `trig_pc_i`=0x40, PCs 0x0,0x4,...,0x60 -> DONE after the write of 0x48; drain yields 0x2C..0x48 (8 entries); `triggered_o`=1.
- Priority and reset:
  - `arm_i` together with `stop_i` and `rvfi_valid` -> next cycle CAPT, `level_o`=0.
  - `rst_i` while in POST -> next cycle IDLE, `triggered_o`=0.
